// File: rtl/sram_arb.sv
// Two-port arbiter and strobe timing controller for the board's 8-bit asynchronous SRAM.
// Video wins by default; a starvation counter forces a CPU grant after STARVE consecutive video wins.
module sram_arb #(
    parameter int AW     = 21,
    parameter int DW     = 8,
    parameter int WAIT   = 2,
    parameter int STARVE = 8
) (
    input  logic          clk,
    input  logic          resetq,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_i,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SU,
        S_WR_PW,
        S_WR_HD
    } state_t;

    localparam logic [3:0] WAIT_M1    = 4'(WAIT - 1);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE);

    state_t        state_q;
    logic [3:0]    wcnt_q;
    logic [7:0]    starve_q;
    logic [7:0]    starve_d;
    logic          rd_vid_q;
    logic          grant_vid;
    logic          grant_cpu;

    logic          cpu_ack_q;
    logic          vid_ack_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] vid_rdata_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] dq_o_q;
    logic          dq_oe_q;
    logic          ce_n_q;
    logic          oe_n_q;
    logic          we_n_q;

    // Arbitration decision and starvation bookkeeping for the current IDLE cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        starve_d  = starve_q;
        if (state_q == S_IDLE) begin
            if (vid_req && !(cpu_req && starve_q == STARVE_MAX)) begin
                grant_vid = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end
        end
        if (!cpu_req || grant_cpu) begin
            starve_d = '0;
        end else if (grant_vid && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            starve_q    <= '0;
            rd_vid_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            addr_q      <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            starve_q  <= starve_d;
            cpu_ack_q <= 1'b0;
            vid_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                    if (grant_vid) begin
                        state_q  <= S_RD;
                        rd_vid_q <= 1'b1;
                        addr_q   <= vid_addr;
                        ce_n_q   <= 1'b0;
                        oe_n_q   <= 1'b0;
                        wcnt_q   <= WAIT_M1;
                    end else if (grant_cpu) begin
                        rd_vid_q <= 1'b0;
                        addr_q   <= cpu_addr;
                        ce_n_q   <= 1'b0;
                        if (cpu_we) begin
                            state_q <= S_WR_SU;
                            dq_oe_q <= 1'b1;
                            dq_o_q  <= cpu_wdata;
                        end else begin
                            state_q <= S_RD;
                            oe_n_q  <= 1'b0;
                            wcnt_q  <= WAIT_M1;
                        end
                    end
                end
                S_RD: begin
                    if (wcnt_q == 4'd0) begin
                        state_q <= S_IDLE;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        if (rd_vid_q) begin
                            vid_rdata_q <= sram_dq_i;
                            vid_ack_q   <= 1'b1;
                        end else begin
                            cpu_rdata_q <= sram_dq_i;
                            cpu_ack_q   <= 1'b1;
                        end
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                S_WR_SU: begin
                    state_q <= S_WR_PW;
                    we_n_q  <= 1'b0;
                    wcnt_q  <= WAIT_M1;
                end
                S_WR_PW: begin
                    if (wcnt_q == 4'd0) begin
                        state_q <= S_WR_HD;
                        we_n_q  <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                S_WR_HD: begin
                    // Address and data stay put for the hold cycle; the bus is released on IDLE entry.
                    state_q   <= S_IDLE;
                    ce_n_q    <= 1'b1;
                    dq_oe_q   <= 1'b0;
                    cpu_ack_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign vid_rdata  = vid_rdata_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

    // Bus-contention guards on the pins.
    a_oe_we_excl: assert property (@(posedge clk) disable iff (!resetq) !(!oe_n_q && !we_n_q));
    a_dq_vs_oe:   assert property (@(posedge clk) disable iff (!resetq) !(dq_oe_q && !oe_n_q));

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb: directed protocol cases plus randomized two-port traffic
// checked against a byte-addressed reference memory and latency bounds derived from the arbitration rules.
module tb_sram_arb;

    localparam int AW        = 21;
    localparam int DW        = 8;
    localparam int WAIT      = 2;
    localparam int STARVE    = 8;
    localparam int BUDGET    = 200;
    localparam int CPU_BOUND = (STARVE + 1) * (WAIT + 1) + WAIT + 5;
    localparam int VID_BOUND = (WAIT + 3) + (WAIT + 1) + 2;

    logic          clk = 1'b0;
    logic          resetq = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_i = 8'hEE;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    sram_arb #(.AW(AW), .DW(DW), .WAIT(WAIT), .STARVE(STARVE)) dut (
        .clk        (clk),
        .resetq     (resetq),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rdata  (vid_rdata),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pin-level SRAM model (mem) and the transaction-level reference contents (ref_mem).
    logic [7:0] mem     [int unsigned];
    logic [7:0] ref_mem [int unsigned];

    function automatic logic [7:0] patt(input int unsigned a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'(a >> 16) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] sram_rd(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return patt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input int unsigned a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return patt(a);
    endfunction

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[32'(sram_addr)] = sram_dq_oe ? sram_dq_o : 8'hEE;
        sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_rd(32'(sram_addr)) : 8'hEE;
    end

    always @(negedge clk) begin
        if (resetq) begin
            check("oe_we_overlap", 32'(!sram_oe_n && !sram_we_n), 32'd0);
            check("dqoe_during_oe", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
        end
    end

    int c_lat, c_ce, c_oe, c_we, c_su, c_hd, c_dqoe;
    int v_lat;

    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                              output logic [DW-1:0] rd);
        bit ok;
        bit seen;
        ok = 1'b0;
        seen = 1'b0;
        c_lat = 0; c_ce = 0; c_oe = 0; c_we = 0; c_su = 0; c_hd = 0; c_dqoe = 0;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            c_lat++;
            if (!sram_ce_n) begin
                c_ce++;
                if (!sram_oe_n) c_oe++;
                if (sram_dq_oe) c_dqoe++;
                if (!sram_we_n) begin
                    c_we++;
                    seen = 1'b1;
                end else if (!seen) begin
                    c_su++;
                end else begin
                    c_hd++;
                end
            end
            if (cpu_ack) begin
                ok = 1'b1;
                break;
            end
        end
        cpu_req = 1'b0;
        rd = cpu_rdata;
        check("cpu_done", 32'(ok), 32'd1);
        if (ok && we) ref_mem[32'(addr)] = wd;
        if (ok && !we) check("cpu_rdata", 32'(cpu_rdata), 32'(ref_rd(32'(addr))));
        @(negedge clk);
        check("cpu_ack_pulse", 32'(cpu_ack), 32'd0);
    endtask

    task automatic vid_access(input logic [AW-1:0] addr);
        bit ok;
        ok = 1'b0;
        v_lat = 0;
        vid_addr = addr; vid_req = 1'b1;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            v_lat++;
            if (vid_ack) begin
                ok = 1'b1;
                break;
            end
        end
        vid_req = 1'b0;
        check("vid_done", 32'(ok), 32'd1);
        if (ok) check("vid_rdata", 32'(vid_rdata), 32'(ref_rd(32'(addr))));
        @(negedge clk);
        check("vid_ack_pulse", 32'(vid_ack), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [DW-1:0] rd;
    int            v_cnt, rounds, acks, ce_lo;
    bit            found;
    bit            cpu_done;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b1110);
        check("rst_acks", 32'({cpu_ack, vid_ack}), 32'd0);
        check("rst_data", 32'({cpu_rdata, vid_rdata, sram_dq_o}), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        resetq = 1'b1;
        @(negedge clk);

        // 1: CPU read
        mem[32'h000123] = 8'hA5;
        ref_mem[32'h000123] = 8'hA5;
        cpu_access(1'b0, 21'h000123, 8'h00, rd);
        check("t1_rdata", 32'(rd), 32'hA5);
        check("t1_latency", 32'(c_lat), 32'(WAIT + 1));
        check("t1_ce_cycles", 32'(c_ce), 32'(WAIT));
        check("t1_oe_cycles", 32'(c_oe), 32'(WAIT));
        check("t1_we_cycles", 32'(c_we), 32'd0);

        // 2: CPU write to the top address, then read back
        cpu_access(1'b1, 21'h1FFFFF, 8'h3C, rd);
        check("t2_latency", 32'(c_lat), 32'(WAIT + 3));
        check("t2_ce_cycles", 32'(c_ce), 32'(WAIT + 2));
        check("t2_setup", 32'(c_su), 32'd1);
        check("t2_we_cycles", 32'(c_we), 32'(WAIT));
        check("t2_hold", 32'(c_hd), 32'd1);
        check("t2_dqoe_cycles", 32'(c_dqoe), 32'(WAIT + 2));
        check("t2_oe_cycles", 32'(c_oe), 32'd0);
        check("t2_mem", 32'(sram_rd(32'h1FFFFF)), 32'h3C);
        cpu_access(1'b0, 21'h1FFFFF, 8'h00, rd);
        check("t2_readback", 32'(rd), 32'h3C);

        // 3: simultaneous requests, video first
        fork
            cpu_access(1'b0, 21'h000077, 8'h00, rd);
            vid_access(21'h100200);
        join
        check("t3_vid_latency", 32'(v_lat), 32'(WAIT + 1));
        check("t3_cpu_latency", 32'(c_lat), 32'(2 * WAIT + 2));

        // 4: continuous video traffic against a held CPU request
        vid_addr = 21'h100333; cpu_addr = 21'h000044; cpu_we = 1'b0;
        vid_req = 1'b1; cpu_req = 1'b1;
        v_cnt = 0; rounds = 0;
        for (int k = 0; k < 400 && rounds < 3; k++) begin
            @(negedge clk);
            if (vid_ack) begin
                v_cnt++;
                check("t4_vid_rdata", 32'(vid_rdata), 32'(ref_rd(32'h100333)));
            end
            if (cpu_ack) begin
                check("t4_vid_grants_before_cpu", 32'(v_cnt), 32'(STARVE));
                check("t4_cpu_rdata", 32'(cpu_rdata), 32'(ref_rd(32'h000044)));
                v_cnt = 0;
                rounds++;
            end
        end
        check("t4_rounds", 32'(rounds), 32'd3);
        vid_req = 1'b0; cpu_req = 1'b0;
        repeat (WAIT + 4) @(negedge clk);

        // 5: reset in the middle of the write pulse
        cpu_we = 1'b1; cpu_addr = 21'h0ABCDE; cpu_wdata = 8'h99; cpu_req = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!sram_we_n) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_in_write_pulse", 32'(found), 32'd1);
        resetq = 1'b0;
        #1;
        check("t5_rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b1110);
        check("t5_rst_ack", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        resetq = 1'b1;
        acks = 0; ce_lo = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack || vid_ack) acks++;
            if (!sram_ce_n) ce_lo++;
        end
        check("t5_no_ack", 32'(acks), 32'd0);
        check("t5_idle", 32'(ce_lo), 32'd0);
        cpu_access(1'b0, 21'h000123, 8'h00, rd);
        check("t5_read_after_reset", 32'(rd), 32'hA5);

        // 6: video request dropped one cycle after grant
        vid_addr = 21'h1ABCDE; vid_req = 1'b1;
        @(negedge clk);
        vid_req = 1'b0;
        acks = 0;
        ce_lo = !sram_ce_n ? 1 : 0;
        repeat (8) begin
            @(negedge clk);
            if (!sram_ce_n) ce_lo++;
            if (vid_ack) begin
                acks++;
                check("t6_vid_rdata", 32'(vid_rdata), 32'(ref_rd(32'h1ABCDE)));
            end
        end
        check("t6_vid_acks", 32'(acks), 32'd1);
        check("t6_ce_cycles", 32'(ce_lo), 32'(WAIT));

        // Randomized two-port traffic
        cpu_done = 1'b0;
        fork
            begin
                logic          w;
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                logic [DW-1:0] r;
                for (int t = 0; t < 40; t++) begin
                    w = 1'($urandom_range(0, 1));
                    a = 21'h000040 | 21'($urandom_range(0, 15));
                    d = 8'($urandom);
                    cpu_access(w, a, d, r);
                    check("rnd_cpu_latency_bound", 32'(c_lat <= CPU_BOUND), 32'd1);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                cpu_done = 1'b1;
            end
            begin
                while (!cpu_done) begin
                    vid_access(21'h100000 | 21'($urandom_range(0, 255)));
                    check("rnd_vid_latency_bound", 32'(v_lat <= VID_BOUND), 32'd1);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
